// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between producer/consumer logic and fifo_ctrl.
// The almost-full/almost-empty signals exist only when FIFO_ALMOST_FLAGS_EN is defined.
interface fifo_ctrl_if #(
    parameter int ADDR_SIZE = 10
);
    logic                 i_wrEn;
    logic                 i_rdEn;
    logic                 i_flush;
    logic                 o_ramWe;
    logic [ADDR_SIZE-1:0] o_ramWAddr;
    logic [ADDR_SIZE-1:0] o_ramRAddr;
    logic                 o_rdValid;
    logic                 o_full;
    logic                 o_empty;
    logic [ADDR_SIZE:0]   o_count;
    logic                 o_overflow;
    logic                 o_underflow;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic                 o_almostFull;
    logic                 o_almostEmpty;
`endif

    modport master (
        output i_wrEn, i_rdEn, i_flush,
        input  o_ramWe, o_ramWAddr, o_ramRAddr, o_rdValid, o_full, o_empty,
               o_count, o_overflow, o_underflow
`ifdef FIFO_ALMOST_FLAGS_EN
        , input o_almostFull, o_almostEmpty
`endif
    );

    modport slave (
        input  i_wrEn, i_rdEn, i_flush,
        output o_ramWe, o_ramWAddr, o_ramRAddr, o_rdValid, o_full, o_empty,
               o_count, o_overflow, o_underflow
`ifdef FIFO_ALMOST_FLAGS_EN
        , output o_almostFull, o_almostEmpty
`endif
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving a dual-port ram with a registered read address.
// Optional almost-full/almost-empty flags are enabled by defining FIFO_ALMOST_FLAGS_EN.
module fifo_ctrl #(
    parameter int ADDR_SIZE = 10
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    parameter int AF_LEVEL  = (2**ADDR_SIZE) - 4,
    parameter int AE_LEVEL  = 4
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    fifo_ctrl_if.slave io_bus
);
    logic [ADDR_SIZE:0] r_wrPtr;
    logic [ADDR_SIZE:0] r_rdPtr;
    logic [ADDR_SIZE:0] r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_rdValid;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_pushOk;
    logic               w_popOk;
    logic [ADDR_SIZE:0] w_wrPtrNext;
    logic [ADDR_SIZE:0] w_rdPtrNext;
    logic [ADDR_SIZE:0] w_countNext;
    logic               w_fullNext;
    logic               w_emptyNext;

    // Acceptance uses only the registered flags, so a same-cycle pop never frees room for a push.
    assign w_pushOk = io_bus.i_wrEn & ~r_full & ~io_bus.i_flush;
    assign w_popOk  = io_bus.i_rdEn & ~r_empty & ~io_bus.i_flush;

    always_comb begin
        w_wrPtrNext = r_wrPtr;
        w_rdPtrNext = r_rdPtr;
        if (io_bus.i_flush) begin
            w_wrPtrNext = '0;
            w_rdPtrNext = '0;
        end else begin
            if (w_pushOk) w_wrPtrNext = r_wrPtr + (ADDR_SIZE+1)'(1);
            if (w_popOk)  w_rdPtrNext = r_rdPtr + (ADDR_SIZE+1)'(1);
        end
        w_countNext = w_wrPtrNext - w_rdPtrNext;
        w_emptyNext = (w_wrPtrNext == w_rdPtrNext);
        w_fullNext  = (w_wrPtrNext[ADDR_SIZE-1:0] == w_rdPtrNext[ADDR_SIZE-1:0]) &&
                      (w_wrPtrNext[ADDR_SIZE] != w_rdPtrNext[ADDR_SIZE]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_rdValid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wrPtr   <= w_wrPtrNext;
            r_rdPtr   <= w_rdPtrNext;
            r_count   <= w_countNext;
            r_full    <= w_fullNext;
            r_empty   <= w_emptyNext;
            r_rdValid <= w_popOk;
            if (io_bus.i_wrEn & r_full & ~io_bus.i_flush)  r_overflow  <= 1'b1;
            if (io_bus.i_rdEn & r_empty & ~io_bus.i_flush) r_underflow <= 1'b1;
        end
    end

`ifdef FIFO_ALMOST_FLAGS_EN
    logic r_almostFull;
    logic r_almostEmpty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_almostFull  <= 1'b0;
            r_almostEmpty <= 1'b1;
        end else begin
            r_almostFull  <= (w_countNext >= (ADDR_SIZE+1)'(AF_LEVEL));
            r_almostEmpty <= (w_countNext <= (ADDR_SIZE+1)'(AE_LEVEL));
        end
    end

    assign io_bus.o_almostFull  = r_almostFull;
    assign io_bus.o_almostEmpty = r_almostEmpty;
`endif

    // Write strobe is gated by reset so nothing reaches the ram while rst_n is low.
    assign io_bus.o_ramWe      = w_pushOk & rst_n;
    assign io_bus.o_ramWAddr   = r_wrPtr[ADDR_SIZE-1:0];
    assign io_bus.o_ramRAddr   = r_rdPtr[ADDR_SIZE-1:0];
    assign io_bus.o_rdValid    = r_rdValid;
    assign io_bus.o_full       = r_full;
    assign io_bus.o_empty      = r_empty;
    assign io_bus.o_count      = r_count;
    assign io_bus.o_overflow   = r_overflow;
    assign io_bus.o_underflow  = r_underflow;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl at ADDR_SIZE=3 with a small behavioural ram model.
module tb_fifo_ctrl;
    localparam int AS = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wrData;
    logic [7:0] mem [8];
    logic [AS-1:0] rAddrQ;
    logic [7:0] rData;
    int         testsRun = 0;
    int         testsFailed = 0;
    int         expAddr;

    fifo_ctrl_if #(.ADDR_SIZE(AS)) bus ();

    fifo_ctrl #(.ADDR_SIZE(AS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // Ram model: write on the edge, registered read address, data visible the cycle after.
    always @(posedge clk) begin
        if (bus.o_ramWe) mem[bus.o_ramWAddr] <= wrData;
        rAddrQ <= bus.o_ramRAddr;
    end
    assign rData = mem[rAddrQ];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic fl, input logic [7:0] d);
        bus.i_wrEn  = wr;
        bus.i_rdEn  = rd;
        bus.i_flush = fl;
        wrData      = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hAA);
        checkOutput("rst_we", 32'(bus.o_ramWe), 32'd0);
        tick();
        checkOutput("rst_count", 32'(bus.o_count), 32'd0);
        checkOutput("rst_empty", 32'(bus.o_empty), 32'd1);
        checkOutput("rst_full", 32'(bus.o_full), 32'd0);
        checkOutput("rst_valid", 32'(bus.o_rdValid), 32'd0);
        checkOutput("rst_waddr", 32'(bus.o_ramWAddr), 32'd0);
`ifdef FIFO_ALMOST_FLAGS_EN
        checkOutput("rst_af", 32'(bus.o_almostFull), 32'd0);
        checkOutput("rst_ae", 32'(bus.o_almostEmpty), 32'd1);
`endif
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("idle_we", 32'(bus.o_ramWe), 32'd0);
        tick();
        checkOutput("idle_empty", 32'(bus.o_empty), 32'd1);
        checkOutput("idle_count", 32'(bus.o_count), 32'd0);

        // Fill to full, then one rejected push.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
            checkOutput("fill_we", 32'(bus.o_ramWe), 32'd1);
            checkOutput("fill_waddr", 32'(bus.o_ramWAddr), 32'(i));
            tick();
            checkOutput("fill_count", 32'(bus.o_count), 32'(i + 1));
`ifdef FIFO_ALMOST_FLAGS_EN
            checkOutput("fill_af", 32'(bus.o_almostFull), 32'((i + 1) >= 4));
            checkOutput("fill_ae", 32'(bus.o_almostEmpty), 32'((i + 1) <= 4));
`endif
        end
        checkOutput("fill_full", 32'(bus.o_full), 32'd1);
        checkOutput("fill_empty", 32'(bus.o_empty), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h99);
        checkOutput("ovf_we", 32'(bus.o_ramWe), 32'd0);
        tick();
        checkOutput("ovf_flag", 32'(bus.o_overflow), 32'd1);
        checkOutput("ovf_count", 32'(bus.o_count), 32'd8);

        // Drain in order, then one rejected pop.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
            checkOutput("drain_raddr", 32'(bus.o_ramRAddr), 32'(i));
            tick();
            checkOutput("drain_valid", 32'(bus.o_rdValid), 32'd1);
            checkOutput("drain_data", 32'(rData), 32'(8'h10 + i));
            checkOutput("drain_count", 32'(bus.o_count), 32'(7 - i));
        end
        checkOutput("drain_empty", 32'(bus.o_empty), 32'd1);
        checkOutput("drain_udf0", 32'(bus.o_underflow), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        checkOutput("udf_flag", 32'(bus.o_underflow), 32'd1);
        checkOutput("udf_valid", 32'(bus.o_rdValid), 32'd0);
        checkOutput("udf_count", 32'(bus.o_count), 32'd0);

        // Wrap: pointers start at address 0 (after one full lap) and cross 7->0 repeatedly.
        expAddr = 0;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 5; k++) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h20 + r * 5 + k));
                checkOutput("wrap_waddr", 32'(bus.o_ramWAddr), 32'((expAddr + k) % 8));
                tick();
                checkOutput("wrap_pcount", 32'(bus.o_count), 32'(k + 1));
            end
            for (int k = 0; k < 5; k++) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
                checkOutput("wrap_raddr", 32'(bus.o_ramRAddr), 32'((expAddr + k) % 8));
                tick();
                checkOutput("wrap_data", 32'(rData), 32'(8'h20 + r * 5 + k));
                checkOutput("wrap_ccount", 32'(bus.o_count), 32'(4 - k));
            end
            expAddr = (expAddr + 5) % 8;
        end

        // Simultaneous push and pop at mid-level, full and empty.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h30 + k));
            tick();
        end
        checkOutput("sim3_pre", 32'(bus.o_count), 32'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h33);
        checkOutput("sim3_we", 32'(bus.o_ramWe), 32'd1);
        tick();
        checkOutput("sim3_count", 32'(bus.o_count), 32'd3);
        checkOutput("sim3_valid", 32'(bus.o_rdValid), 32'd1);
        checkOutput("sim3_data", 32'(rData), 32'h30);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h34 + k));
            tick();
        end
        checkOutput("simf_full", 32'(bus.o_full), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h99);
        checkOutput("simf_we", 32'(bus.o_ramWe), 32'd0);
        tick();
        checkOutput("simf_count", 32'(bus.o_count), 32'd7);
        checkOutput("simf_full0", 32'(bus.o_full), 32'd0);
        checkOutput("simf_data", 32'(rData), 32'h31);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
            tick();
            checkOutput("simf_drain", 32'(rData), 32'(8'h32 + k));
        end
        checkOutput("sime_empty", 32'(bus.o_empty), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h40);
        checkOutput("sime_we", 32'(bus.o_ramWe), 32'd1);
        tick();
        checkOutput("sime_count", 32'(bus.o_count), 32'd1);
        checkOutput("sime_empty0", 32'(bus.o_empty), 32'd0);
        checkOutput("sime_valid", 32'(bus.o_rdValid), 32'd0);

        // Flush at count 5 keeps sticky flags and restarts pointers at 0.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h41 + k));
            tick();
        end
        checkOutput("fl_pre", 32'(bus.o_count), 32'd5);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h55);
        checkOutput("fl_we", 32'(bus.o_ramWe), 32'd0);
        tick();
        checkOutput("fl_empty", 32'(bus.o_empty), 32'd1);
        checkOutput("fl_count", 32'(bus.o_count), 32'd0);
        checkOutput("fl_full", 32'(bus.o_full), 32'd0);
        checkOutput("fl_valid", 32'(bus.o_rdValid), 32'd0);
        checkOutput("fl_ovf", 32'(bus.o_overflow), 32'd1);
        checkOutput("fl_udf", 32'(bus.o_underflow), 32'd1);
`ifdef FIFO_ALMOST_FLAGS_EN
        checkOutput("fl_af", 32'(bus.o_almostFull), 32'd0);
        checkOutput("fl_ae", 32'(bus.o_almostEmpty), 32'd1);
`endif
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h60);
        checkOutput("fl_waddr", 32'(bus.o_ramWAddr), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("fl_raddr", 32'(bus.o_ramRAddr), 32'd0);
        tick();
        checkOutput("fl_data", 32'(rData), 32'h60);

        // Asynchronous reset in the middle of traffic.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h61);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h62);
        tick();
        checkOutput("ar_pre", 32'(bus.o_count), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_count", 32'(bus.o_count), 32'd0);
        checkOutput("ar_empty", 32'(bus.o_empty), 32'd1);
        checkOutput("ar_ovf", 32'(bus.o_overflow), 32'd0);
        checkOutput("ar_udf", 32'(bus.o_underflow), 32'd0);
        checkOutput("ar_waddr", 32'(bus.o_ramWAddr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
